hazard_ctrl: RTL

Central stall/forward controller for the five-stage MIPS pipeline. Keeps its own scoreboard of destination register (A3) and Tnew for the E, M and W stages. Compares that scoreboard against D-stage source registers and Tuse to raise a single stall. Drives the forward-select lines for the D, E and M operand muxes, and sequences the mult/div unit's busy window.

---
 rtl/hazard_pkg.sv | 49 ++++
 rtl/hazard_slot.sv | 38 +++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types, encodings and match helpers for the pipeline hazard controller.
package hazard_pkg;

  // Tuse value meaning "this source register is not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage operand mux selects
  localparam logic [1:0] D_FWD_RF = 2'd0;
  localparam logic [1:0] D_FWD_E  = 2'd1;
  localparam logic [1:0] D_FWD_M  = 2'd2;
  localparam logic [1:0] D_FWD_W  = 2'd3;

  // E-stage operand mux selects
  localparam logic [1:0] E_FWD_PIPE = 2'd0;
  localparam logic [1:0] E_FWD_M    = 2'd1;
  localparam logic [1:0] E_FWD_W    = 2'd2;

  // M-stage store-data mux selects
  localparam logic M_FWD_PIPE = 1'b0;
  localparam logic M_FWD_W    = 1'b1;

  // Default mult/div busy lengths
  localparam int DEF_MULT_CYC = 5;
  localparam int DEF_DIV_CYC  = 10;

  // One scoreboard entry
  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } slot_t;

  // A stage matches r when it writes a non-zero register equal to r
  function automatic logic slot_match(slot_t s, logic [4:0] r);
    return (s.a3 != 5'd0) && (s.a3 == r);
  endfunction

  // A matching stage blocks a consumer whose result is not ready in time
  function automatic logic slot_blocks(slot_t s, logic [4:0] r, logic [1:0] tuse);
    return slot_match(s, r) && (tuse != TUSE_NONE) && (s.tnew > tuse);
  endfunction

  // A matching stage whose result already exists can feed a bypass
  function automatic logic slot_ready(slot_t s, logic [4:0] r);
    return slot_match(s, r) && (s.tnew == 2'd0);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One scoreboard stage register: captures the upstream entry, inserts a
// bubble on request and optionally ages Tnew by one (saturating at zero).
module hazard_slot
  import hazard_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  slot_t din,
  output slot_t q
);

  slot_t nxt_s;

  // Next entry: bubble, or upstream entry with Tnew aged when enabled
  always_comb begin
    nxt_s = din;
    if (bubble) begin
      nxt_s = '0;
    end else if (DEC && (din.tnew != 2'd0)) begin
      nxt_s.tnew = din.tnew - 2'd1;
    end else begin
      nxt_s.tnew = din.tnew;
    end
  end

  // Stage register, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= nxt_s;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/forward controller: E/M/W scoreboard, stall generation,
// forward-select priority and the mult/div busy counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_Tnew,
  input  logic       D_md,
  input  logic       E_start,
  input  logic       E_is_div,
  output logic       stall,
  output logic [1:0] D_fwd_rs,
  output logic [1:0] D_fwd_rt,
  output logic [1:0] E_fwd_rs,
  output logic [1:0] E_fwd_rt,
  output logic       M_fwd_rt,
  output logic       md_busy
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  slot_t d_slot, e_slot, m_slot, w_slot;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic stall_rs_s, stall_rt_s, stall_md_s;
  logic unused_slot_bits;

  assign d_slot = '{a3: D_A3, tnew: D_Tnew, rs: D_rs, rt: D_rt};

  // D enters E unaged (D_Tnew already counts from E); later stages age by one
  hazard_slot #(.DEC(1'b0)) u_e (.clk(clk), .reset(reset), .bubble(stall), .din(d_slot), .q(e_slot));
  hazard_slot #(.DEC(1'b1)) u_m (.clk(clk), .reset(reset), .bubble(1'b0),  .din(e_slot), .q(m_slot));
  hazard_slot #(.DEC(1'b1)) u_w (.clk(clk), .reset(reset), .bubble(1'b0),  .din(m_slot), .q(w_slot));

  // M never forwards by rs, and W only supplies its A3/Tnew
  assign unused_slot_bits = ^{m_slot.rs, w_slot.rs, w_slot.rt};

  // Stall when a producer in E or M is not ready by the consumer's Tuse,
  // or when a HI/LO user meets a busy mult/div unit
  always_comb begin
    stall_rs_s = slot_blocks(e_slot, D_rs, D_Tuse_rs) | slot_blocks(m_slot, D_rs, D_Tuse_rs);
    stall_rt_s = slot_blocks(e_slot, D_rt, D_Tuse_rt) | slot_blocks(m_slot, D_rt, D_Tuse_rt);
    stall_md_s = D_md & md_busy;
    stall      = stall_rs_s | stall_rt_s | stall_md_s;
  end

  // D-stage forward selects: nearest ready producer wins (E, then M, then W)
  always_comb begin
    D_fwd_rs = D_FWD_RF;
    D_fwd_rt = D_FWD_RF;
    if (slot_ready(e_slot, D_rs))      D_fwd_rs = D_FWD_E;
    else if (slot_ready(m_slot, D_rs)) D_fwd_rs = D_FWD_M;
    else if (slot_ready(w_slot, D_rs)) D_fwd_rs = D_FWD_W;
    else                               D_fwd_rs = D_FWD_RF;
    if (slot_ready(e_slot, D_rt))      D_fwd_rt = D_FWD_E;
    else if (slot_ready(m_slot, D_rt)) D_fwd_rt = D_FWD_M;
    else if (slot_ready(w_slot, D_rt)) D_fwd_rt = D_FWD_W;
    else                               D_fwd_rt = D_FWD_RF;
  end

  // E- and M-stage forward selects from the sources held in the E/M slots
  always_comb begin
    E_fwd_rs = E_FWD_PIPE;
    E_fwd_rt = E_FWD_PIPE;
    M_fwd_rt = M_FWD_PIPE;
    if (slot_ready(m_slot, e_slot.rs))      E_fwd_rs = E_FWD_M;
    else if (slot_ready(w_slot, e_slot.rs)) E_fwd_rs = E_FWD_W;
    else                                    E_fwd_rs = E_FWD_PIPE;
    if (slot_ready(m_slot, e_slot.rt))      E_fwd_rt = E_FWD_M;
    else if (slot_ready(w_slot, e_slot.rt)) E_fwd_rt = E_FWD_W;
    else                                    E_fwd_rt = E_FWD_PIPE;
    if (slot_ready(w_slot, m_slot.rt))      M_fwd_rt = M_FWD_W;
    else                                    M_fwd_rt = M_FWD_PIPE;
  end

  // Busy counter next value: a start always reloads, otherwise count down
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (E_start) begin
      cnt_nxt_s = E_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Busy counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign md_busy = E_start | (cnt_r != {CNT_W{1'b0}});

endmodule
